// File: rtl/ultrasonic_echo_emulator.sv
// Emulates an HC-SR04 style ultrasonic ranger: qualifies a trigger pulse, waits out
// the acoustic burst, returns an echo pulse whose width encodes the target distance.
module ultrasonic_echo_emulator #(
    parameter int TRIG_MIN_CYCLES = 500,
    parameter int BURST_CYCLES    = 10000,
    parameter int CYCLES_PER_CM   = 2900,
    parameter int TIMEOUT_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [7:0] distance,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam int MAX_ECHO  = (TIMEOUT_CYCLES > 255 * CYCLES_PER_CM) ? TIMEOUT_CYCLES
                                                                       : 255 * CYCLES_PER_CM;
    localparam int MAX_PHASE = (HOLDOFF_CYCLES > BURST_CYCLES) ? HOLDOFF_CYCLES : BURST_CYCLES;
    localparam int MAX_EB    = (MAX_ECHO > MAX_PHASE) ? MAX_ECHO : MAX_PHASE;
    localparam int MAX_CNT   = (MAX_EB > TRIG_MIN_CYCLES) ? MAX_EB : TRIG_MIN_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_MIN_C   = CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPC          = CNT_W'(CYCLES_PER_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       dist_q, dist_d;
    logic             trig_q;
    logic             echo_q, echo_d;
    logic             busy_q, busy_d;
    logic             trig_err_q, trig_err_d;

    logic             trig_rise;
    logic             trig_fall;
    logic [CNT_W-1:0] echo_len;
    logic [CNT_W-1:0] echo_last;

    assign trig_rise = trig & ~trig_q;
    assign trig_fall = ~trig & trig_q;

    // Counter width always covers 255 * CYCLES_PER_CM, so the product never truncates.
    assign echo_len  = CNT_W'(dist_q) * CPC;
    assign echo_last = (dist_q == 8'd0) ? TIMEOUT_LAST : (echo_len - ONE);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dist_d     = dist_q;
        trig_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG_HI;
                    cnt_d   = ONE;
                end
            end

            TRIG_HI: begin
                if (trig_fall) begin
                    if (cnt_q >= TRIG_MIN_C) begin
                        state_d = BURST;
                        dist_d  = distance;
                        cnt_d   = BURST_LAST;
                    end else begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        trig_err_d = 1'b1;
                    end
                end else if (cnt_q < TRIG_MIN_C) begin
                    cnt_d = cnt_q + ONE;
                end
            end

            // Phase counters load "length - 1" and leave the phase on the cycle they hit zero.
            BURST: begin
                if (cnt_q == '0) begin
                    state_d = ECHO;
                    cnt_d   = echo_last;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            ECHO: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLDOFF_LAST;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they never glitch.
        busy_d = (state_d == BURST) || (state_d == ECHO) || (state_d == HOLDOFF);
        echo_d = (state_d == ECHO);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dist_q     <= '0;
            trig_q     <= 1'b0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dist_q     <= dist_d;
            trig_q     <= trig;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = trig_err_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator with shortened timing parameters;
// a negedge monitor timestamps echo/busy edges and counts trig_err cycles.
module tb_ultrasonic_echo_emulator;

    localparam int TMIN  = 10;
    localparam int BURST = 20;
    localparam int CPC   = 4;
    localparam int TOUT  = 2000;
    localparam int HOLD  = 50;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] distance;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int n_checks;
    int n_errors;
    int cyc;
    int t_fall;

    int  n_rise, n_busy, n_err;
    int  rise_cyc, fall_cyc, busy_fall_cyc;
    logic echo_prev, busy_prev;

    ultrasonic_echo_emulator #(
        .TRIG_MIN_CYCLES(TMIN),
        .BURST_CYCLES   (BURST),
        .CYCLES_PER_CM  (CPC),
        .TIMEOUT_CYCLES (TOUT),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .distance(distance),
        .echo    (echo),
        .busy    (busy),
        .trig_err(trig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        n_rise = 0; n_busy = 0; n_err = 0;
        rise_cyc = -1; fall_cyc = -1; busy_fall_cyc = -1;
        echo_prev = 1'b0; busy_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (echo && !echo_prev) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (!echo && echo_prev) fall_cyc = cyc;
        if (busy && !busy_prev) n_busy++;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        if (trig_err) n_err++;
        echo_prev = echo;
        busy_prev = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        @(posedge clk);
        #1;
        n_rise = 0; n_busy = 0; n_err = 0;
        rise_cyc = -1; fall_cyc = -1; busy_fall_cyc = -1;
    endtask

    // Holds trig high for exactly n sampling edges; returns on the negedge trig drops.
    task automatic pulse_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        trig     = 1'b0;
        distance = 8'd0;

        wait_cycles(3);
        check("reset echo", echo, 0);
        check("reset busy", busy, 0);
        check("reset trig_err", trig_err, 0);
        rst = 1'b0;
        wait_cycles(2);

        // Nominal measurement, 25 cm -> 100-cycle echo
        clear_stats();
        distance = 8'd25;
        pulse_trig(10);
        t_fall = cyc + 1;
        wait_cycles(1);
        check("t1 busy in burst", busy, 1);
        wait_cycles(200);
        check("t1 burst delay", rise_cyc - t_fall, 20);
        check("t1 echo width", fall_cyc - rise_cyc, 100);
        check("t1 holdoff", busy_fall_cyc - fall_cyc, 50);
        check("t1 echo count", n_rise, 1);
        check("t1 trig_err", n_err, 0);

        // Trigger one cycle too short
        clear_stats();
        pulse_trig(9);
        wait_cycles(200);
        check("t2 trig_err pulses", n_err, 1);
        check("t2 echo count", n_rise, 0);
        check("t2 busy count", n_busy, 0);

        // No target -> timeout width; farthest target
        clear_stats();
        distance = 8'd0;
        pulse_trig(10);
        wait_cycles(2100);
        check("t3 timeout width", fall_cyc - rise_cyc, 2000);
        clear_stats();
        distance = 8'd255;
        pulse_trig(10);
        wait_cycles(1120);
        check("t3 max width", fall_cyc - rise_cyc, 1020);

        // Distance latched at acceptance; trig noise during ECHO/HOLDOFF ignored
        clear_stats();
        distance = 8'd30;
        pulse_trig(10);
        t_fall = cyc + 1;
        wait_cycles(5);
        distance = 8'd5;
        wait_cycles(25);
        pulse_trig(12);
        wait_cycles(110);
        pulse_trig(3);
        wait_cycles(5);
        pulse_trig(10);
        wait_cycles(100);
        check("t4 burst delay", rise_cyc - t_fall, 20);
        check("t4 echo width", fall_cyc - rise_cyc, 120);
        check("t4 echo count", n_rise, 1);
        check("t4 trig_err", n_err, 0);
        check("t4 busy count", n_busy, 1);
        check("t4 holdoff", busy_fall_cyc - fall_cyc, 50);

        // Reset mid-ECHO abandons the measurement
        clear_stats();
        distance = 8'd25;
        pulse_trig(10);
        wait_cycles(50);
        check("t5 echo before rst", echo, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5 echo after rst", echo, 0);
        check("t5 busy after rst", busy, 0);
        rst = 1'b0;
        wait_cycles(300);
        check("t5 no echo resume", n_rise, 1);
        check("t5 idle busy", busy, 0);
        clear_stats();
        pulse_trig(10);
        t_fall = cyc + 1;
        wait_cycles(200);
        check("t5 remeasure delay", rise_cyc - t_fall, 20);
        check("t5 remeasure width", fall_cyc - rise_cyc, 100);

        // Long trig saturates width counter and is still accepted
        clear_stats();
        distance = 8'd10;
        pulse_trig(1000);
        t_fall = cyc + 1;
        wait_cycles(150);
        check("t6 long trig delay", rise_cyc - t_fall, 20);
        check("t6 long trig width", fall_cyc - rise_cyc, 40);
        check("t6 long trig err", n_err, 0);

        // trig already high at HOLDOFF exit must not retrigger
        clear_stats();
        pulse_trig(10);
        wait_cycles(80);
        trig = 1'b1;
        wait_cycles(100);
        trig = 1'b0;
        wait_cycles(50);
        check("t6 single echo", n_rise, 1);
        check("t6 single busy", n_busy, 1);
        check("t6 no trig_err", n_err, 0);
        check("t6 end busy", busy, 0);
        check("t6 width", fall_cyc - rise_cyc, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
